csr_unit: RTL and testbench
===========================

CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have port csr_addr, input, 12, CSR address from the MEM-stage instruction.
REQ-004 SHALL have port csr_wr_en, input, 1, CSR write strobe.
REQ-005 SHALL have port csr_wdata, input, 32, CSR write data.
REQ-006 SHALL have port csr_rdata, output, 32, CSR read data.
REQ-007 SHALL have port mem_valid, input, 1, MEM-stage instruction is real, not a bubble.
REQ-008 SHALL have port pc_mem, input, 32, PC of the MEM-stage instruction.
REQ-009 SHALL have port is_mret, input, 1, MEM-stage instruction is MRET.
REQ-010 SHALL have port ext_irq, input, 1, external interrupt, asynchronous level.
REQ-011 SHALL have port timer_irq, input, 1, timer interrupt, asynchronous level.
REQ-012 SHALL have port epc_taken, output, 1, one-cycle redirect pulse to fetch; also the pipeline flush.
REQ-013 SHALL have port epc, output, 32, redirect target, valid while epc_taken=1.

Function
REQ-014 SHALL implement these registers: mstatus 0x300 (MIE bit3, MPIE bit7, other bits 0); mie 0x304 (MTIE bit7, MEIE bit11); mtvec 0x305; mepc 0x341; mcause 0x342; mip 0x344.
REQ-015 SHALL make mip read-only, with MTIP=bit7 and MEIP=bit11 taken from the synchronised irq levels.
REQ-016 SHALL drive csr_rdata combinationally from csr_addr; unmapped address reads 0.
REQ-017 SHALL write the addressed register on the clk edge when csr_wr_en=1 and mem_valid=1; writes to unmapped addresses or mip are ignored.
REQ-018 SHALL take an interrupt when all hold: FSM in RUN; mem_valid=1; mstatus.MIE=1; (MEIP&MEIE) or (MTIP&MTIE).
REQ-019 SHALL give external priority over timer; mcause = 0x8000000B for external, 0x80000007 for timer.
REQ-020 SHALL, on trap at edge N: mepc<=pc_mem; mcause<=cause; MPIE<=MIE; MIE<=0; epc<={mtvec[31:2],2'b00}; epc_taken=1 during cycle N+1 only.
REQ-021 SHALL, on MRET (RUN, mem_valid=1, is_mret=1, no trap): MIE<=MPIE; MPIE<=1; epc<=mepc; epc_taken pulses one cycle.
REQ-022 SHALL give a trap precedence over a simultaneous MRET and over a CSR write; the losing effects are dropped (mepc = PC of that instruction, so it re-executes).
REQ-023 SHALL use FSM RUN -> REDIRECT (1 cycle, epc_taken=1) -> HOLDOFF (2 cycles via a 2-bit down-counter) -> RUN.
REQ-024 SHALL, in REDIRECT and HOLDOFF, accept no new trap, MRET or CSR write, because flushed bubbles are draining.
REQ-025 SHALL hold epc_taken=0 in RUN and HOLDOFF; epc holds its last value.
REQ-026 SHALL sample a pending interrupt that deasserts before being taken nowhere (level semantics, no latching).

Reset
REQ-027 SHALL, while reset=1 at an edge, clear mstatus, mie, mepc, mcause, epc, the synchronisers, and the holdoff counter; set mtvec<=CSR_MTVEC_RST (0x00000040); enter RUN; hold epc_taken=0.
REQ-028 SHALL let reset asserted in REDIRECT or HOLDOFF abort to RUN with no further epc_taken pulse.

Structure
REQ-029 SHALL place the CSR address constants, mcause codes, bit indices, CSR_MTVEC_RST, and the FSM state enum in package csr_pkg.
REQ-030 SHALL instantiate sub-module csr_irq_sync (2-flop synchroniser, reset to 0) once per irq input.

Verification
REQ-031 SHALL cover: reset, then read all six CSRs -> mtvec=0x00000040, others 0.
REQ-032 SHALL cover: write mie=0x800, mstatus=0x8, raise ext_irq, pc_mem=0x100 -> 3 cycles later (2 sync + 1) epc_taken=1, epc=0x40; mepc=0x100; mcause=0x8000000B; mstatus=0x80.
REQ-033 SHALL cover: ext_irq and timer_irq together, both enabled -> mcause=0x8000000B.
REQ-034 SHALL cover: MRET after REQ-032 with mem_valid=1 -> epc=0x100 pulse; mstatus=0x88.
REQ-035 SHALL cover: interrupt pending coinciding with csr_wr_en to mtvec=0x200 -> trap taken, mtvec stays 0x40; a second irq during HOLDOFF is ignored until RUN.
REQ-036 SHALL cover: irq enabled but mem_valid=0 for 5 cycles -> no epc_taken; trap fires on the first mem_valid=1 cycle.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR unit.
//   CSR addresses, mcause codes, bit positions inside mstatus/mie/mip,
//   the mtvec reset value and the redirect FSM state encoding.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_EXT     = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TMR     = 32'h8000_0007;
    localparam logic [31:0] CSR_MTVEC_RST = 32'h0000_0040;

    // mstatus bits
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    // mie / mip bits
    localparam int MTI_BIT  = 7;
    localparam int MEI_BIT  = 11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_REDIRECT,
        ST_HOLDOFF
    } state_t;

endpackage

// File: rtl/csr_irq_sync.sv
// csr_irq_sync: two-flop synchroniser for one asynchronous interrupt level.
//   clk      - rising-edge clock
//   reset    - synchronous, active-high; clears both flops
//   irq      - asynchronous level input
//   irq_sync - level, two clk edges after irq
module csr_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic irq_sync
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= irq;
            s2 <= s1;
        end
    end

    assign irq_sync = s2;

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSRs, interrupt entry and MRET redirect.
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   csr_addr/wr_en/wdata  - CSR access from the MEM-stage instruction
//   csr_rdata             - combinational read of csr_addr (unmapped -> 0)
//   mem_valid, pc_mem     - MEM-stage instruction is real, and its PC
//   is_mret               - MEM-stage instruction is MRET
//   ext_irq, timer_irq    - asynchronous interrupt levels
//   epc_taken, epc        - one-cycle redirect/flush pulse and its target
module csr_unit
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] csr_addr,
    input  logic        csr_wr_en,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic        mem_valid,
    input  logic [31:0] pc_mem,
    input  logic        is_mret,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic        epc_taken,
    output logic [31:0] epc
);

    state_t      state;
    state_t      next_state;
    logic [1:0]  hold_cnt;

    logic        st_mie;
    logic        st_mpie;
    logic        ie_mtie;
    logic        ie_meie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;

    logic        meip;
    logic        mtip;

    csr_irq_sync u_sync_ext (.clk(clk), .reset(reset), .irq(ext_irq),   .irq_sync(meip));
    csr_irq_sync u_sync_tmr (.clk(clk), .reset(reset), .irq(timer_irq), .irq_sync(mtip));

    logic ext_hit;
    logic tmr_hit;
    logic run_ok;
    logic trap_take;
    logic mret_take;
    logic wr_take;

    // Only a real instruction in RUN can trap, retire MRET or write a CSR;
    // during REDIRECT/HOLDOFF the MEM stage holds flushed bubbles.
    assign run_ok    = (state == ST_RUN) && mem_valid;
    assign ext_hit   = meip && ie_meie;
    assign tmr_hit   = mtip && ie_mtie;
    assign trap_take = run_ok && st_mie && (ext_hit || tmr_hit);
    assign mret_take = run_ok && is_mret && !trap_take;
    assign wr_take   = run_ok && csr_wr_en && !trap_take;

    // Read mux
    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;

    always_comb begin
        mstatus_val           = '0;
        mstatus_val[MIE_BIT]  = st_mie;
        mstatus_val[MPIE_BIT] = st_mpie;
        mie_val               = '0;
        mie_val[MTI_BIT]      = ie_mtie;
        mie_val[MEI_BIT]      = ie_meie;
        mip_val               = '0;
        mip_val[MTI_BIT]      = mtip;
        mip_val[MEI_BIT]      = meip;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = mstatus_val;
            CSR_MIE:     csr_rdata = mie_val;
            CSR_MTVEC:   csr_rdata = mtvec;
            CSR_MEPC:    csr_rdata = mepc;
            CSR_MCAUSE:  csr_rdata = mcause;
            CSR_MIP:     csr_rdata = mip_val;
            default:     csr_rdata = '0;
        endcase
    end

    // CSR state. A trap drops any write/MRET of the same instruction; when
    // MRET and a CSR write coincide, MRET's mstatus update wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            ie_mtie <= 1'b0;
            ie_meie <= 1'b0;
            mtvec   <= CSR_MTVEC_RST;
            mepc    <= '0;
            mcause  <= '0;
            epc     <= '0;
        end else if (trap_take) begin
            mepc    <= pc_mem;
            mcause  <= ext_hit ? CAUSE_EXT : CAUSE_TMR;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
            epc     <= {mtvec[31:2], 2'b00};
        end else begin
            if (wr_take) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        st_mie  <= csr_wdata[MIE_BIT];
                        st_mpie <= csr_wdata[MPIE_BIT];
                    end
                    CSR_MIE: begin
                        ie_mtie <= csr_wdata[MTI_BIT];
                        ie_meie <= csr_wdata[MEI_BIT];
                    end
                    CSR_MTVEC:  mtvec  <= csr_wdata;
                    CSR_MEPC:   mepc   <= csr_wdata;
                    CSR_MCAUSE: mcause <= csr_wdata;
                    default: ;
                endcase
            end
            if (mret_take) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
                epc     <= mepc;
            end
        end
    end

    // Redirect FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
        end else begin
            state <= next_state;
            // Loaded with 1 so HOLDOFF lasts for counts 1 and 0.
            if (state == ST_REDIRECT)
                hold_cnt <= 2'd1;
            else if (state == ST_HOLDOFF && hold_cnt != 2'd0)
                hold_cnt <= hold_cnt - 2'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:      if (trap_take || mret_take) next_state = ST_REDIRECT;
            ST_REDIRECT: next_state = ST_HOLDOFF;
            ST_HOLDOFF:  if (hold_cnt == 2'd0) next_state = ST_RUN;
            default:     next_state = ST_RUN;
        endcase
    end

    // Gated by reset so an abort out of REDIRECT never shows a pulse.
    assign epc_taken = (state == ST_REDIRECT) && !reset;

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: randomized + directed bench for csr_unit with a reference
// model and scoreboard queues (read data, redirect pulses).
module tb_csr_unit;
    import csr_pkg::*;

    logic        clk = 1'b1;
    logic        reset = 1'b1;
    logic [11:0] csr_addr = '0;
    logic        csr_wr_en = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        mem_valid = 1'b0;
    logic [31:0] pc_mem = '0;
    logic        is_mret = 1'b0;
    logic        ext_irq = 1'b0;
    logic        timer_irq = 1'b0;
    logic        epc_taken;
    logic [31:0] epc;

    always #5 clk = ~clk;

    csr_unit dut (
        .clk(clk), .reset(reset), .csr_addr(csr_addr), .csr_wr_en(csr_wr_en),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .mem_valid(mem_valid),
        .pc_mem(pc_mem), .is_mret(is_mret), .ext_irq(ext_irq),
        .timer_irq(timer_irq), .epc_taken(epc_taken), .epc(epc)
    );

    typedef struct {
        logic [31:0] tgt;
        int          cyc;
    } redir_t;

    redir_t      rq[$];
    logic [31:0] dq[$];

    int  nchk = 0;
    int  npass = 0;
    int  cyc = 0;
    int  last_rst = -100;
    bit  mvalid = 1'b0;
    bit  lv_e[0:4095];
    bit  lv_t[0:4095];
    bit  e_lv = 1'b0;
    bit  t_lv = 1'b0;
    bit  ov_en = 1'b0;
    logic [31:0] ov_val = '0;

    // Reference model state
    bit          m_mie, m_mpie, m_mtie, m_meie;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    int          busy;

    logic [11:0] alist[8] = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC,
                              CSR_MCAUSE, CSR_MIP, 12'h123, 12'h000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [31:0] mread(input logic [11:0] a, input bit se, input bit st);
        case (a)
            CSR_MSTATUS: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            CSR_MIE:     return (m_mtie ? 32'h80 : 32'h0) | (m_meie ? 32'h800 : 32'h0);
            CSR_MTVEC:   return m_mtvec;
            CSR_MEPC:    return m_mepc;
            CSR_MCAUSE:  return m_mcause;
            CSR_MIP:     return (st ? 32'h80 : 32'h0) | (se ? 32'h800 : 32'h0);
            default:     return 32'h0;
        endcase
    endfunction

    // Monitor: pops expectations when the DUT presents data or a redirect.
    always @(negedge clk) begin
        logic [31:0] x;
        redir_t      r;
        if (dq.size() > 0) begin
            x = dq.pop_front();
            chk("csr_rdata", csr_rdata, x);
        end
        if (rq.size() > 0 && rq[0].cyc < cyc) begin
            nchk++;
            $display("FAIL missed_redirect: no pulse, required at cycle %0d", rq[0].cyc);
            void'(rq.pop_front());
        end
        if (epc_taken === 1'b1) begin
            if (rq.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_redirect: epc_taken=1 at cycle %0d, required 0", cyc);
            end else begin
                r = rq.pop_front();
                chk("epc", epc, r.tgt);
                chk("redirect_cycle", cyc, r.cyc);
            end
        end
    end

    // One clock of stimulus. The interrupt a trap decision sees is the
    // level driven two cycles earlier (synchroniser latency), or 0 if a
    // reset happened since then.
    task automatic step(input bit rst, input bit mv, input bit wr, input logic [11:0] a,
                        input logic [31:0] wd, input bit mr, input logic [31:0] pc);
        bit se, st, o_mie, o_mpie;
        logic [31:0] o_mepc;
        reset = rst; mem_valid = mv; csr_wr_en = wr; csr_addr = a; csr_wdata = wd;
        is_mret = mr; pc_mem = pc; ext_irq = e_lv; timer_irq = t_lv;
        lv_e[cyc] = e_lv;
        lv_t[cyc] = t_lv;
        se = (cyc >= 2 && cyc - 2 > last_rst) ? lv_e[cyc-2] : 1'b0;
        st = (cyc >= 2 && cyc - 2 > last_rst) ? lv_t[cyc-2] : 1'b0;
        if (mvalid) dq.push_back(ov_en ? ov_val : mread(a, se, st));
        ov_en = 1'b0;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0;
            m_mtvec = 32'h40; m_mepc = 0; m_mcause = 0; busy = 0;
            last_rst = cyc; mvalid = 1'b1;
            while (rq.size() > 0 && rq[rq.size()-1].cyc == cyc) void'(rq.pop_back());
        end else if (busy > 0) begin
            busy--;
        end else if (mv) begin
            if (m_mie && ((se && m_meie) || (st && m_mtie))) begin
                m_mepc   = pc;
                m_mcause = (se && m_meie) ? 32'h8000000B : 32'h80000007;
                m_mpie   = m_mie;
                m_mie    = 0;
                rq.push_back('{m_mtvec & 32'hFFFF_FFFC, cyc + 1});
                busy = 3;
            end else begin
                o_mie = m_mie; o_mpie = m_mpie; o_mepc = m_mepc;
                if (wr) begin
                    case (a)
                        CSR_MSTATUS: begin m_mie = wd[3]; m_mpie = wd[7]; end
                        CSR_MIE:     begin m_mtie = wd[7]; m_meie = wd[11]; end
                        CSR_MTVEC:   m_mtvec = wd;
                        CSR_MEPC:    m_mepc = wd;
                        CSR_MCAUSE:  m_mcause = wd;
                        default: ;
                    endcase
                end
                if (mr) begin
                    m_mie  = o_mpie;
                    m_mpie = 1;
                    rq.push_back('{o_mepc, cyc + 1});
                    busy = 3;
                end
                if (o_mie) ; // previous MIE only matters through the trap test
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 12'h000, 0, 0, 0);
    endtask

    task automatic run(input int n, input logic [31:0] pc);
        for (int i = 0; i < n; i++) step(0, 1, 0, 12'h000, 0, 0, pc);
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
        step(0, 1, 1, a, d, 0, 32'h0);
    endtask

    task automatic mret();
        step(0, 1, 0, 12'h000, 0, 1, 32'h0);
    endtask

    task automatic expect_rd(input logic [11:0] a, input logic [31:0] v);
        ov_en = 1'b1;
        ov_val = v;
        step(0, 0, 0, a, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // Reset values
        expect_rd(CSR_MSTATUS, 32'h0);
        expect_rd(CSR_MIE,     32'h0);
        expect_rd(CSR_MTVEC,   32'h40);
        expect_rd(CSR_MEPC,    32'h0);
        expect_rd(CSR_MCAUSE,  32'h0);
        expect_rd(CSR_MIP,     32'h0);
        expect_rd(12'h7C0,     32'h0);

        // External interrupt entry
        wr_csr(CSR_MIE, 32'h800);
        wr_csr(CSR_MSTATUS, 32'h8);
        e_lv = 1;
        run(3, 32'h100);
        e_lv = 0;
        idle(4);
        expect_rd(CSR_MEPC,    32'h100);
        expect_rd(CSR_MCAUSE,  32'h8000000B);
        expect_rd(CSR_MSTATUS, 32'h80);

        // MRET back to 0x100
        mret();
        idle(4);
        expect_rd(CSR_MSTATUS, 32'h88);

        // Both interrupts: external wins
        wr_csr(CSR_MIE, 32'h880);
        e_lv = 1; t_lv = 1;
        run(3, 32'h200);
        e_lv = 0; t_lv = 0;
        idle(4);
        expect_rd(CSR_MCAUSE, 32'h8000000B);
        expect_rd(CSR_MEPC,   32'h200);
        mret();
        idle(4);

        // Trap beats a coincident mtvec write; irq during HOLDOFF waits
        e_lv = 1;
        idle(2);
        step(0, 1, 1, CSR_MTVEC, 32'h200, 0, 32'h300);
        idle(4);
        expect_rd(CSR_MTVEC, 32'h40);
        expect_rd(CSR_MEPC,  32'h300);
        mret();
        run(5, 32'h400);
        e_lv = 0;
        idle(4);
        expect_rd(CSR_MEPC, 32'h400);
        mret();
        idle(4);

        // Pending irq but bubbles only; trap on first real instruction
        e_lv = 1;
        idle(7);
        run(1, 32'h500);
        e_lv = 0;
        idle(4);
        expect_rd(CSR_MEPC, 32'h500);

        // Reset during REDIRECT suppresses the pulse
        mret();
        step(1, 0, 0, 0, 0, 0, 0);
        idle(4);
        expect_rd(CSR_MSTATUS, 32'h0);
        expect_rd(CSR_MTVEC,   32'h40);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) e_lv = ~e_lv;
            if ($urandom_range(15) == 0) t_lv = ~t_lv;
            step(bit'($urandom_range(99) == 0), bit'($urandom_range(1)),
                 bit'($urandom_range(3) == 0), alist[$urandom_range(7)],
                 $urandom, bit'($urandom_range(7) == 0), $urandom);
        end
        e_lv = 0; t_lv = 0;
        idle(6);
        chk("redirects_outstanding", rq.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
